// File: rtl/nlfsr_search_ctrl_if.sv
// Lane and result bus between the search controller, its engines and the
// result consumer.
// Handshake rules:
//   - lane_done is a level. A lane raises it when its candidate is finished and
//     holds it until it sees its lane_res pulse. lane_found qualifies it.
//   - The result port is valid/ready. A word transfers on a rising edge where
//     res_valid and res_ready are both high. The head word stays stable until it
//     is popped. Only start or reset discard it.
interface nlfsr_search_ctrl_if #(
    parameter int LANES       = 4,
    parameter int NUM_OF_TAPS = 6,
    parameter int LANE_W      = 4
);
    logic [LANES-1:0]               lane_done;
    logic [LANES-1:0]               lane_found;
    logic [LANES*NUM_OF_TAPS*8-1:0] lane_taps;
    logic [LANES-1:0]               lane_ena;
    logic [LANES-1:0]               lane_res;
    logic                           res_valid;
    logic [NUM_OF_TAPS*8-1:0]       res_taps;
    logic [LANE_W-1:0]              res_lane;
    logic                           res_ready;

    // Controller side
    modport master (
        input  lane_done, lane_found, lane_taps, res_ready,
        output lane_ena, lane_res, res_valid, res_taps, res_lane
    );

    // Lane engines and result consumer side
    modport slave (
        output lane_done, lane_found, lane_taps, res_ready,
        input  lane_ena, lane_res, res_valid, res_taps, res_lane
    );
endinterface

// File: rtl/nlfsr_search_ctrl.sv
// Multi-lane NLFSR tap-search controller.
// It arbitrates lane completions, restarts the lanes and queues found tap
// sets in a first-word-fall-through FIFO. It also counts attempts and ends a
// campaign on the first find (mode 0) or at the attempt limit (mode 1).
// state_dbg encoding: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE.
module nlfsr_search_ctrl #(
    parameter int NUM_OF_TAPS  = 6,
    parameter int SIZE         = 16,
    parameter int LANES        = 4,
    parameter int LANE_W       = 4,
    parameter int RESULT_DEPTH = 4,
    parameter int MAX_ATTEMPTS = 0
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                restart,
    input  logic                mode,
    nlfsr_search_ctrl_if.master bus,
    output logic                started,
    output logic                busy,
    output logic                exhausted,
    output logic [15:0]         found_cnt,
    output logic [31:0]         attempts,
    output logic [1:0]          state_dbg
);
    localparam int TAP_W = NUM_OF_TAPS * 8;
    localparam int ENT_W = LANE_W + TAP_W;
    localparam int PTR_W = $clog2(RESULT_DEPTH);
    localparam logic [31:0] MAX_A = 32'(MAX_ATTEMPTS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Reject parameter sets the datapath cannot represent
    if (LANES < 1 || LANES > 16 || (1 << LANE_W) < LANES || RESULT_DEPTH < 2 ||
        (RESULT_DEPTH & (RESULT_DEPTH - 1)) != 0 || SIZE < 2) begin : g_bad_params
        $error("nlfsr_search_ctrl: illegal parameter set");
    end

    logic [1:0]        state;
    logic              mode_q;
    logic [LANES-1:0]  lane_res_q;
    logic [LANES-1:0]  lane_ena_q;
    logic [ENT_W-1:0]  mem [RESULT_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [ENT_W-1:0]  head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              can_push;
    logic [LANES-1:0]  elig;
    logic              ev_hit;
    logic              ev_found;
    logic [LANE_W-1:0] ev_lane;
    logic [TAP_W-1:0]  ev_taps;
    logic              go;
    logic              accept;
    logic              push;
    logic              hit_limit;
    logic [31:0]       attempts_inc;
    logic [15:0]       found_inc;

    // The pointers carry one extra wrap bit, so full and empty can be told apart
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = bus.res_valid & bus.res_ready;
    assign can_push   = ~fifo_full | pop;

    // A lane is masked while its own restart pulse is out, so it is never counted twice
    assign elig = bus.lane_done & ~lane_res_q & (~bus.lane_found | {LANES{can_push}});

    // Lowest eligible index wins; blocked found lanes are already out of elig
    always_comb begin
        ev_hit   = 1'b0;
        ev_found = 1'b0;
        ev_lane  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (elig[i]) begin
                ev_hit   = 1'b1;
                ev_found = bus.lane_found[i];
                ev_lane  = LANE_W'(i);
            end
        end
    end

    assign ev_taps      = bus.lane_taps[int'(ev_lane) * TAP_W +: TAP_W];
    assign go           = start && (state == S_IDLE || state == S_DONE);
    assign accept       = (state == S_RUN) && !restart && ev_hit;
    assign push         = accept && ev_found;
    assign attempts_inc = (&attempts) ? attempts : attempts + 32'd1;
    assign found_inc    = (&found_cnt) ? found_cnt : found_cnt + 16'd1;
    assign hit_limit    = accept && mode_q && (MAX_A != 32'd0) && (attempts_inc == MAX_A);

    // Campaign state machine, lane enables and sticky status flags
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            started    <= 1'b0;
            exhausted  <= 1'b0;
            lane_ena_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        mode_q     <= mode;
                        started    <= 1'b1;
                        exhausted  <= 1'b0;
                        lane_ena_q <= '1;
                    end
                end
                S_RUN: begin
                    if ((push && !mode_q) || hit_limit) begin
                        state      <= S_DRAIN;
                        lane_ena_q <= '0;
                    end
                    if (hit_limit) begin
                        exhausted <= 1'b1;
                    end
                end
                default: begin
                    if (fifo_empty) begin
                        state <= S_DONE;
                    end
                end
            endcase
        end
    end

    // One-cycle restart pulses: all lanes on start/restart, the served lane otherwise
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            lane_res_q <= '0;
        end else if (go || (state == S_RUN && restart)) begin
            lane_res_q <= '1;
        end else if (accept) begin
            lane_res_q <= LANES'(1) << ev_lane;
        end else begin
            lane_res_q <= '0;
        end
    end

    // Saturating campaign counters
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            attempts  <= '0;
            found_cnt <= '0;
        end else if (go) begin
            attempts  <= '0;
            found_cnt <= '0;
        end else if (accept) begin
            attempts <= attempts_inc;
            if (ev_found) begin
                found_cnt <= found_inc;
            end
        end
    end

    // Result FIFO pointers; start discards anything left over
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (go) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Result storage holds data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {ev_lane, ev_taps};
        end
    end

    assign head          = mem[rd_ptr[PTR_W-1:0]];
    assign bus.res_valid = ~fifo_empty;
    assign bus.res_taps  = fifo_empty ? '0 : head[TAP_W-1:0];
    assign bus.res_lane  = fifo_empty ? '0 : head[ENT_W-1:TAP_W];
    assign bus.lane_res  = lane_res_q;
    assign bus.lane_ena  = lane_ena_q;
    assign busy          = (state == S_RUN) || (state == S_DRAIN);
    assign state_dbg     = state;
endmodule

// File: tb/tb_nlfsr_search_ctrl.sv
// Bench for nlfsr_search_ctrl. Two instances share control inputs: one with an
// unlimited attempt budget and one with a budget of three. A queue-based
// behavioural model predicts every output cycle by cycle.
module tb_nlfsr_search_ctrl;
    localparam int LANES = 4;
    localparam int NT    = 6;
    localparam int TW    = NT * 8;
    localparam int LW    = 4;
    localparam int DEPTH = 4;
    localparam int EW    = LW + TW;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    // ---------------- clock / reset / shared controls ----------------
    logic clk       = 1'b0;
    logic res       = 1'b0;
    logic start     = 1'b0;
    logic restart   = 1'b0;
    logic mode      = 1'b0;
    logic res_ready = 1'b0;
    int   total     = 0;
    int   bad       = 0;

    always #5 clk = ~clk;

    // ---------------- per-instance lane inputs and DUT outputs ----------------
    logic [LANES-1:0]    done_i   [2];
    logic [LANES-1:0]    found_i  [2];
    logic [TW-1:0]       taps_i   [2][LANES];
    logic [LANES*TW-1:0] taps_flat[2];

    logic [LANES-1:0] lres_o   [2];
    logic [LANES-1:0] lena_o   [2];
    logic             rvalid_o [2];
    logic [TW-1:0]    rtaps_o  [2];
    logic [LW-1:0]    rlane_o  [2];
    logic             started_o[2];
    logic             busy_o   [2];
    logic             exh_o    [2];
    logic [15:0]      found_o  [2];
    logic [31:0]      att_o    [2];
    logic [1:0]       st_o     [2];

    for (genvar k = 0; k < 2; k++) begin : g_flat
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign taps_flat[k][i*TW +: TW] = taps_i[k][i];
        end
    end

    nlfsr_search_ctrl_if #(.LANES(LANES), .NUM_OF_TAPS(NT), .LANE_W(LW)) bif0 ();
    nlfsr_search_ctrl_if #(.LANES(LANES), .NUM_OF_TAPS(NT), .LANE_W(LW)) bif1 ();

    assign bif0.lane_done  = done_i[0];
    assign bif0.lane_found = found_i[0];
    assign bif0.lane_taps  = taps_flat[0];
    assign bif0.res_ready  = res_ready;
    assign bif1.lane_done  = done_i[1];
    assign bif1.lane_found = found_i[1];
    assign bif1.lane_taps  = taps_flat[1];
    assign bif1.res_ready  = res_ready;

    assign lres_o[0]   = bif0.lane_res;
    assign lena_o[0]   = bif0.lane_ena;
    assign rvalid_o[0] = bif0.res_valid;
    assign rtaps_o[0]  = bif0.res_taps;
    assign rlane_o[0]  = bif0.res_lane;
    assign lres_o[1]   = bif1.lane_res;
    assign lena_o[1]   = bif1.lane_ena;
    assign rvalid_o[1] = bif1.res_valid;
    assign rtaps_o[1]  = bif1.res_taps;
    assign rlane_o[1]  = bif1.res_lane;

    nlfsr_search_ctrl #(
        .NUM_OF_TAPS(NT), .SIZE(16), .LANES(LANES), .LANE_W(LW),
        .RESULT_DEPTH(DEPTH), .MAX_ATTEMPTS(0)
    ) dut0 (
        .clk(clk), .res(res), .start(start), .restart(restart), .mode(mode),
        .bus(bif0), .started(started_o[0]), .busy(busy_o[0]),
        .exhausted(exh_o[0]), .found_cnt(found_o[0]), .attempts(att_o[0]),
        .state_dbg(st_o[0])
    );

    nlfsr_search_ctrl #(
        .NUM_OF_TAPS(NT), .SIZE(16), .LANES(LANES), .LANE_W(LW),
        .RESULT_DEPTH(DEPTH), .MAX_ATTEMPTS(3)
    ) dut1 (
        .clk(clk), .res(res), .start(start), .restart(restart), .mode(mode),
        .bus(bif1), .started(started_o[1]), .busy(busy_o[1]),
        .exhausted(exh_o[1]), .found_cnt(found_o[1]), .attempts(att_o[1]),
        .state_dbg(st_o[1])
    );

    // ---------------- behavioural model ----------------
    int               m_st     [2];
    bit               m_mode   [2];
    bit               m_started[2];
    bit               m_exh    [2];
    logic [15:0]      m_found  [2];
    logic [31:0]      m_att    [2];
    logic [LANES-1:0] m_lres   [2];
    logic [LANES-1:0] m_ena    [2];
    logic [EW-1:0]    q0[$];
    logic [EW-1:0]    q1[$];

    function automatic int lim(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [EW-1:0] q_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_pop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void q_push(input int k, input logic [EW-1:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic void q_clear(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endfunction

    function automatic void model_reset(input int k);
        m_st[k]      = M_IDLE;
        m_mode[k]    = 1'b0;
        m_started[k] = 1'b0;
        m_exh[k]     = 1'b0;
        m_found[k]   = '0;
        m_att[k]     = '0;
        m_lres[k]    = '0;
        m_ena[k]     = '0;
        q_clear(k);
    endfunction

    // One clock of the campaign rules for instance k
    function automatic void model_step(input int k);
        int               sz0;
        bit               pop;
        bit               can_push;
        int               cand[$];
        int               sel;
        logic [LANES-1:0] nl;
        sz0 = q_size(k);
        pop = (sz0 > 0) && res_ready;
        nl  = '0;
        if ((m_st[k] == M_IDLE || m_st[k] == M_DONE) && start) begin
            m_st[k]      = M_RUN;
            m_mode[k]    = mode;
            m_started[k] = 1'b1;
            m_exh[k]     = 1'b0;
            m_found[k]   = '0;
            m_att[k]     = '0;
            m_ena[k]     = '1;
            q_clear(k);
            nl           = '1;
        end else begin
            can_push = (sz0 < DEPTH) || pop;
            if (pop) q_pop(k);
            if (m_st[k] == M_RUN && restart) begin
                nl = '1;
            end else if (m_st[k] == M_RUN) begin
                for (int i = 0; i < LANES; i++) begin
                    if (done_i[k][i] && !m_lres[k][i] && (!found_i[k][i] || can_push))
                        cand.push_back(i);
                end
                if (cand.size() > 0) begin
                    sel     = cand[0];
                    nl[sel] = 1'b1;
                    if (m_att[k] != 32'hFFFF_FFFF) m_att[k] = m_att[k] + 32'd1;
                    if (found_i[k][sel]) begin
                        q_push(k, {4'(sel), taps_i[k][sel]});
                        if (m_found[k] != 16'hFFFF) m_found[k] = m_found[k] + 16'd1;
                        if (!m_mode[k]) begin
                            m_st[k]  = M_DRAIN;
                            m_ena[k] = '0;
                        end
                    end
                    if (m_mode[k] && lim(k) != 0 && m_att[k] == 32'(lim(k))) begin
                        m_exh[k] = 1'b1;
                        m_st[k]  = M_DRAIN;
                        m_ena[k] = '0;
                    end
                end
            end else if (m_st[k] == M_DRAIN && sz0 == 0) begin
                m_st[k] = M_DONE;
            end
        end
        m_lres[k] = nl;
    endfunction

    always @(posedge clk or negedge res) begin
        if (!res) begin
            for (int k = 0; k < 2; k++) model_reset(k);
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // ---------------- scoreboard ----------------
    function automatic void check(input int k, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s[%0d]: got %0h, want %0h at %0t", name, k, act, exp, $time);
        end
    endfunction

    function automatic void compare_all(input int k);
        logic [EW-1:0] hd;
        bit            v;
        v = (q_size(k) > 0);
        check(k, "res_valid", 64'(rvalid_o[k]), 64'(v));
        if (v) begin
            hd = q_front(k);
            check(k, "res_taps", 64'(rtaps_o[k]), 64'(hd[TW-1:0]));
            check(k, "res_lane", 64'(rlane_o[k]), 64'(hd[EW-1:TW]));
        end
        check(k, "lane_res", 64'(lres_o[k]), 64'(m_lres[k]));
        check(k, "lane_ena", 64'(lena_o[k]), 64'(m_ena[k]));
        check(k, "started", 64'(started_o[k]), 64'(m_started[k]));
        check(k, "busy", 64'(busy_o[k]), 64'(m_st[k] == M_RUN || m_st[k] == M_DRAIN));
        check(k, "exhausted", 64'(exh_o[k]), 64'(m_exh[k]));
        check(k, "found_cnt", 64'(found_o[k]), 64'(m_found[k]));
        check(k, "attempts", 64'(att_o[k]), 64'(m_att[k]));
        check(k, "state", 64'(st_o[k]), 64'(m_st[k]));
    endfunction

    always @(negedge clk) begin
        if (res) begin
            for (int k = 0; k < 2; k++) compare_all(k);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic lanes_clear();
        for (int k = 0; k < 2; k++) begin
            done_i[k]  = '0;
            found_i[k] = '0;
            for (int i = 0; i < LANES; i++) taps_i[k][i] = '0;
        end
    endtask

    task automatic pulse_start(input logic m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        res = 1'b0;
        lanes_clear();
        tick();
        tick();
        res = 1'b1;
    endtask

    task automatic check_zero(input int k);
        check(k, "rst_started", 64'(started_o[k]), 64'd0);
        check(k, "rst_busy", 64'(busy_o[k]), 64'd0);
        check(k, "rst_exh", 64'(exh_o[k]), 64'd0);
        check(k, "rst_found", 64'(found_o[k]), 64'd0);
        check(k, "rst_att", 64'(att_o[k]), 64'd0);
        check(k, "rst_lres", 64'(lres_o[k]), 64'd0);
        check(k, "rst_lena", 64'(lena_o[k]), 64'd0);
        check(k, "rst_valid", 64'(rvalid_o[k]), 64'd0);
        check(k, "rst_taps", 64'(rtaps_o[k]), 64'd0);
        check(k, "rst_lane", 64'(rlane_o[k]), 64'd0);
        check(k, "rst_state", 64'(st_o[k]), 64'd0);
    endtask

    // Random lane engine: finishes candidates while enabled, clears on its restart pulse
    task automatic lanes_auto(input int k);
        for (int i = 0; i < LANES; i++) begin
            if (lres_o[k][i]) begin
                done_i[k][i] = 1'b0;
            end else if (!done_i[k][i] && lena_o[k][i] && ($urandom_range(0, 99) < 25)) begin
                done_i[k][i]  = 1'b1;
                found_i[k][i] = ($urandom_range(0, 99) < 30);
                taps_i[k][i]  = 48'({$urandom, $urandom});
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] oh;
        lanes_clear();
        repeat (3) tick();
        check_zero(0);
        check_zero(1);
        res = 1'b1;
        tick();

        // Stop-on-first: lane 2 finds
        pulse_start(1'b0);
        check(0, "start_lres", 64'(lres_o[0]), 64'hF);
        check(0, "start_ena", 64'(lena_o[0]), 64'hF);
        check(0, "start_state", 64'(st_o[0]), 64'd1);
        tick();
        check(0, "lres_clear", 64'(lres_o[0]), 64'h0);
        done_i[0][2]  = 1'b1;
        found_i[0][2] = 1'b1;
        taps_i[0][2]  = 48'h0102_0304_0506;
        tick();
        done_i[0][2] = 1'b0;
        check(0, "t1_valid", 64'(rvalid_o[0]), 64'd1);
        check(0, "t1_lane", 64'(rlane_o[0]), 64'd2);
        check(0, "t1_taps", 64'(rtaps_o[0]), 64'h0102_0304_0506);
        check(0, "t1_found", 64'(found_o[0]), 64'd1);
        check(0, "t1_att", 64'(att_o[0]), 64'd1);
        check(0, "t1_lres", 64'(lres_o[0]), 64'h4);
        check(0, "t1_ena", 64'(lena_o[0]), 64'h0);
        check(0, "t1_state", 64'(st_o[0]), 64'd2);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check(0, "t1_popped", 64'(rvalid_o[0]), 64'd0);
        tick();
        check(0, "t1_done", 64'(st_o[0]), 64'd3);

        // Four simultaneous fails are served in index order
        pulse_start(1'b0);
        tick();
        done_i[0]  = 4'hF;
        found_i[0] = 4'h0;
        for (int j = 0; j < 4; j++) begin
            tick();
            oh = 4'(1 << j);
            check(0, "t2_lres", 64'(lres_o[0]), 64'(oh));
            done_i[0][j] = 1'b0;
        end
        check(0, "t2_att", 64'(att_o[0]), 64'd4);
        check(0, "t2_state", 64'(st_o[0]), 64'd1);

        // Collect mode with a full FIFO and a blocked fifth find
        do_reset();
        pulse_start(1'b1);
        tick();
        done_i[0]  = 4'hF;
        found_i[0] = 4'hF;
        for (int i = 0; i < LANES; i++) taps_i[0][i] = 48'hA0 + 48'(i);
        for (int j = 0; j < 4; j++) begin
            tick();
            oh = 4'(1 << j);
            check(0, "t3_lres", 64'(lres_o[0]), 64'(oh));
            done_i[0][j] = 1'b0;
        end
        check(0, "t3_found4", 64'(found_o[0]), 64'd4);
        check(0, "t3_head", 64'(rlane_o[0]), 64'd0);
        done_i[0][0]  = 1'b1;
        found_i[0][0] = 1'b1;
        taps_i[0][0]  = 48'hBEEF;
        done_i[0][1]  = 1'b1;
        found_i[0][1] = 1'b0;
        tick();
        done_i[0][1] = 1'b0;
        check(0, "t3_failpass", 64'(lres_o[0]), 64'h2);
        check(0, "t3_att5", 64'(att_o[0]), 64'd5);
        check(0, "t3_found_held", 64'(found_o[0]), 64'd4);
        tick();
        check(0, "t3_hold", 64'(lres_o[0]), 64'h0);
        res_ready = 1'b1;
        tick();
        res_ready    = 1'b0;
        done_i[0][0] = 1'b0;
        check(0, "t3_admit", 64'(lres_o[0]), 64'h1);
        check(0, "t3_found5", 64'(found_o[0]), 64'd5);
        check(0, "t3_att6", 64'(att_o[0]), 64'd6);
        check(0, "t3_newhead", 64'(rlane_o[0]), 64'd1);

        // Attempt limit of three on the second instance
        do_reset();
        pulse_start(1'b1);
        tick();
        done_i[1]  = 4'b0111;
        found_i[1] = 4'h0;
        for (int j = 0; j < 3; j++) begin
            tick();
            oh = 4'(1 << j);
            check(1, "t4_lres", 64'(lres_o[1]), 64'(oh));
            done_i[1][j] = 1'b0;
        end
        check(1, "t4_exh", 64'(exh_o[1]), 64'd1);
        check(1, "t4_drain", 64'(st_o[1]), 64'd2);
        check(1, "t4_ena", 64'(lena_o[1]), 64'h0);
        tick();
        check(1, "t4_done", 64'(st_o[1]), 64'd3);
        check(1, "t4_busy", 64'(busy_o[1]), 64'd0);
        pulse_start(1'b1);
        check(1, "t4_exh_clr", 64'(exh_o[1]), 64'd0);
        check(1, "t4_att_clr", 64'(att_o[1]), 64'd0);
        check(1, "t4_run", 64'(st_o[1]), 64'd1);
        tick();

        // Restart drops a coincident fail
        done_i[0][0]  = 1'b1;
        found_i[0][0] = 1'b0;
        restart       = 1'b1;
        tick();
        restart      = 1'b0;
        done_i[0][0] = 1'b0;
        check(0, "t5_lres", 64'(lres_o[0]), 64'hF);
        check(0, "t5_att", 64'(att_o[0]), 64'd0);
        tick();

        // Asynchronous reset with a result waiting
        done_i[0][1]  = 1'b1;
        found_i[0][1] = 1'b1;
        taps_i[0][1]  = 48'h123;
        tick();
        done_i[0][1] = 1'b0;
        check(0, "t6_valid", 64'(rvalid_o[0]), 64'd1);
        res = 1'b0;
        #1;
        check_zero(0);
        check_zero(1);
        lanes_clear();
        tick();
        res = 1'b1;
        tick();

        // Random campaigns on both instances
        for (int c = 0; c < 4000; c++) begin
            if (c % 800 == 799) begin
                do_reset();
            end
            mode      = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 99) < 3);
            restart   = ($urandom_range(0, 99) < 2);
            res_ready = ($urandom_range(0, 99) < 40);
            for (int k = 0; k < 2; k++) lanes_auto(k);
            tick();
        end
        start     = 1'b0;
        restart   = 1'b0;
        res_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
